// File: rtl/nios_pio_in_irq.sv
// ----------------------------------------------------------------------------
// nios_pio_in_irq
//
// Avalon-MM input PIO with per-bit edge capture and a maskable interrupt.
// Board inputs (buttons, switches, status lines) pass through a synchroniser
// into d_sync. Each bit's edges are latched in edgecapture until software
// clears them. The CPU interrupt comes either from the synchronised level
// or from the captured edges, gated by irqmask.
//
// Register map (word addresses):
//   0 data        (RO)  synchronised input d_sync
//   1 reserved    (RO)  reads 0, writes ignored
//   2 irqmask     (RW)  per-bit interrupt enable
//   3 edgecapture (RW)  sticky edge flags; write clears (see BIT_CLEAR)
//
// Parameters:
//   WIDTH        input port width, 1..32
//   SYNC_STAGES  synchroniser depth, 2..4
//   EDGE_TYPE    0 rising, 1 falling, 2 any edge
//   IRQ_MODE     0 level (d_sync & irqmask), 1 edge (edgecapture & irqmask)
//   BIT_CLEAR    1 write-1-to-clear per bit, 0 any write clears every bit
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register select
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data, bits [WIDTH-1:0] used
//   in_port     asynchronous external inputs
//   readdata    registered read data, zero-extended, one cycle latency
//   irq         interrupt request, active high, combinational from flops
// ----------------------------------------------------------------------------
module nios_pio_in_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 1,
  parameter int BIT_CLEAR   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Zero-extend a port-width value onto the 32-bit bus; written as a function
  // so WIDTH=32 needs no zero-length replication.
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r            = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // Synchroniser chain: element 0 samples in_port, the top element is d_sync.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  d_sync;

  logic [WIDTH-1:0] d_prev_q,      d_prev_d;
  logic [WIDTH-1:0] irqmask_q,     irqmask_d;
  logic [WIDTH-1:0] edgecapture_q, edgecapture_d;
  logic [31:0]      readdata_q,    readdata_d;

  logic [WIDTH-1:0] rise, fall, evt;
  logic             wr_en;

  // Only the low WIDTH bits of writedata carry information; the reduction
  // keeps the remaining bits formally consumed.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign d_sync = sync_q[SYNC_STAGES-1];
  assign wr_en  = chipselect & ~write_n;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], in_port};
    d_prev_d = d_sync;
  end

  // Edge detection against the previous synchronised sample.
  always_comb begin
    rise = d_sync & ~d_prev_q;
    fall = ~d_sync & d_prev_q;
    if (EDGE_TYPE == 0) begin
      evt = rise;
    end else if (EDGE_TYPE == 1) begin
      evt = fall;
    end else begin
      evt = rise | fall;
    end
  end

  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_en && (address == ADDR_MASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
  end

  // Clear first, then OR in new events: an edge arriving in the same cycle as
  // its clear survives, so software never loses an event.
  always_comb begin
    edgecapture_d = edgecapture_q;
    if (wr_en && (address == ADDR_EDGE)) begin
      if (BIT_CLEAR != 0) begin
        edgecapture_d = edgecapture_q & ~writedata[WIDTH-1:0];
      end else begin
        edgecapture_d = '0;
      end
    end
    edgecapture_d = edgecapture_d | evt;
  end

  // Read mux is registered every cycle regardless of chipselect; reads have
  // no side effects, so the free-running capture is harmless.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d = zext(d_sync);
      ADDR_RSVD: readdata_d = '0;
      ADDR_MASK: readdata_d = zext(irqmask_q);
      ADDR_EDGE: readdata_d = zext(edgecapture_q);
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q        <= '0;
      d_prev_q      <= '0;
      irqmask_q     <= '0;
      edgecapture_q <= '0;
      readdata_q    <= '0;
    end else begin
      sync_q        <= sync_d;
      d_prev_q      <= d_prev_d;
      irqmask_q     <= irqmask_d;
      edgecapture_q <= edgecapture_d;
      readdata_q    <= readdata_d;
    end
  end

  assign readdata = readdata_q;

  generate
    if (IRQ_MODE == 0) begin : g_irq_level
      assign irq = |(d_sync & irqmask_q);
    end else begin : g_irq_edge
      assign irq = |(edgecapture_q & irqmask_q);
    end
  endgenerate

endmodule

// File: tb/tb_nios_pio_in_irq.sv
module tb_nios_pio_in_irq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;
  logic [31:0]      readdata_lvl;
  logic             irq_lvl;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Edge-mode instance: rising capture, per-bit clear.
  nios_pio_in_irq #(
    .WIDTH(WIDTH), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1), .BIT_CLEAR(1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  // Level-mode instance sharing the same bus and inputs.
  nios_pio_in_irq #(
    .WIDTH(WIDTH), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0), .BIT_CLEAR(1)
  ) u_dut_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_lvl), .irq(irq_lvl)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_rd(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic sample_rd(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s scoreboard empty got=0x%08h", tag, readdata);
    end else begin
      e = exp_q.pop_front();
      check(tag, readdata, e);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string tag);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    expect_rd(e);
    @(negedge clk);
    sample_rd(tag);
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;

    // Reset state
    idle(2);
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;

    bus_read(2'd0, 32'd0, "t1_data");
    bus_read(2'd2, 32'd0, "t1_mask");
    bus_read(2'd3, 32'd0, "t1_edge");
    check("t1_irq", 32'(irq), 32'd0);
    check("t1_irq_lvl", 32'(irq_lvl), 32'd0);

    // Mask write with junk in the upper bits, then one-cycle read latency
    bus_write(2'd2, 32'hFFFF_FF02);
    address    = 2'd2;
    chipselect = 1'b1;
    #1;
    check("t1_lat_before", readdata, 32'd0);
    expect_rd(32'h02);
    @(negedge clk);
    sample_rd("t1_lat_after");
    chipselect = 1'b0;

    // Writes to data and reserved are ignored
    bus_write(2'd0, 32'hFF);
    bus_write(2'd1, 32'hFF);
    bus_read(2'd2, 32'h02, "t1_mask_keep");
    bus_read(2'd1, 32'd0, "t1_rsvd");

    // Rising edges 0x00 -> 0x5A, track latency cycle by cycle
    in_port    = 8'h5A;
    address    = 2'd0;
    chipselect = 1'b1;
    expect_rd(32'd0);
    @(negedge clk);
    sample_rd("t2_data_c1");
    check("t2_irq_c1", 32'(irq), 32'd0);
    check("t2_irq_lvl_c1", 32'(irq_lvl), 32'd0);
    expect_rd(32'd0);
    @(negedge clk);
    sample_rd("t2_data_c2");
    check("t2_irq_c2", 32'(irq), 32'd0);
    check("t2_irq_lvl_c2", 32'(irq_lvl), 32'd1);
    expect_rd(32'h5A);
    @(negedge clk);
    sample_rd("t2_data_c3");
    check("t2_irq_c3", 32'(irq), 32'd1);
    chipselect = 1'b0;
    bus_read(2'd3, 32'h5A, "t2_edge");

    // Per-bit clear of bit1 drops irq, other bits stay
    bus_write(2'd3, 32'h02);
    check("t3_irq_cleared", 32'(irq), 32'd0);
    bus_read(2'd3, 32'h58, "t3_edge");

    // Falling edge not captured, then clear racing a new rising edge
    bus_write(2'd2, 32'h08);
    check("t4_irq_mask8", 32'(irq), 32'd1);
    in_port = 8'h52;
    idle(3);
    bus_read(2'd3, 32'h58, "t4_no_fall");
    bus_write(2'd3, 32'hFF);
    check("t4_irq_clr_all", 32'(irq), 32'd0);
    bus_read(2'd3, 32'd0, "t4_edge_clr");
    in_port = 8'h5A;
    idle(2);
    bus_write(2'd3, 32'h08);
    check("t4_irq_held", 32'(irq), 32'd1);
    bus_read(2'd3, 32'h08, "t4_edge_set_wins");

    // Level mode follows d_sync with SYNC_STAGES clocks of lag
    bus_write(2'd2, 32'h01);
    check("t5_lvl_idle", 32'(irq_lvl), 32'd0);
    in_port = 8'h5B;
    @(negedge clk);
    check("t5_rise_c1", 32'(irq_lvl), 32'd0);
    @(negedge clk);
    check("t5_rise_c2", 32'(irq_lvl), 32'd1);
    in_port = 8'h5A;
    @(negedge clk);
    check("t5_fall_c1", 32'(irq_lvl), 32'd1);
    @(negedge clk);
    check("t5_fall_c2", 32'(irq_lvl), 32'd0);

    // Fill edgecapture and mask, then asynchronous reset
    bus_write(2'd2, 32'hFF);
    in_port = 8'h00;
    idle(3);
    bus_write(2'd3, 32'hFF);
    in_port = 8'hFF;
    idle(3);
    bus_read(2'd3, 32'hFF, "t6_edge_full");
    check("t6_irq_full", 32'(irq), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_readdata", readdata, 32'd0);
    check("t6_async_irq", 32'(irq), 32'd0);
    check("t6_async_irq_lvl", 32'(irq_lvl), 32'd0);
    check("t6_async_readdata_lvl", readdata_lvl, 32'd0);
    idle(2);
    reset_n = 1'b1;
    bus_read(2'd2, 32'd0, "t6_mask_after_rst");
    bus_read(2'd3, 32'd0, "t6_edge_after_rst");
    idle(1);
    bus_read(2'd3, 32'hFF, "t6_held_high_captured");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
